// File: rtl/ring_osc_counter.sv
// Ring-oscillator measurement front end: enables the oscillator, prescales it in
// its own domain, synchronizes the divided tap into clk and counts tap transitions
// over a programmable window of clk cycles.
module ring_osc_counter #(
    parameter int unsigned DIV_LOG2      = 4,
    parameter int unsigned WIN_W         = 16,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIN_W-1:0] window,
    output logic             osc_en,
    input  logic             osc_in,
    output logic             busy,
    output logic             valid,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam int unsigned SET_W = $clog2(SETTLE_CYCLES);
    localparam int unsigned TMR_W = (WIN_W > SET_W) ? WIN_W : SET_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [DIV_LOG2-1:0] presc_q, presc_d;
    logic [2:0]         sync_q, sync_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_sh_q, ovf_sh_d;
    logic               osc_en_q, osc_en_d;
    logic               busy_q, busy_d;
    logic               valid_q, valid_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               event_c;

    // Prescaler next value in the oscillator domain
    always_comb begin
        presc_d = presc_q + DIV_LOG2'(1);
    end

    // Prescaler register, clocked by the oscillator and cleared by the system reset
    always_ff @(posedge osc_in or posedge reset) begin
        if (reset) presc_q <= '0;
        else       presc_q <= presc_d;
    end

    // Two-flop synchronizer for the tap followed by an edge-detect flop
    always_comb begin
        sync_d  = {sync_q[1:0], presc_q[DIV_LOG2-1]};
        event_c = sync_q[1] ^ sync_q[2];
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = SETTLE;
            SETTLE:  if (tmr_q == '0) state_d = (win_q == '0) ? DONE : MEASURE;
            MEASURE: if (tmr_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        tmr_d      = tmr_q;
        win_d      = win_q;
        cnt_d      = cnt_q;
        ovf_sh_d   = ovf_sh_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    win_d    = window;
                    tmr_d    = TMR_W'(SETTLE_CYCLES - 1);
                    cnt_d    = '0;
                    ovf_sh_d = 1'b0;
                end
            end
            SETTLE: begin
                if (tmr_q == '0) tmr_d = TMR_W'(win_q) - TMR_W'(1);
                else             tmr_d = tmr_q - TMR_W'(1);
            end
            MEASURE: begin
                tmr_d = tmr_q - TMR_W'(1);
                if (event_c) begin
                    if (cnt_q == '1) ovf_sh_d = 1'b1;
                    else             cnt_d    = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
        // Result is loaded on entry to DONE so it is visible together with valid
        if (state_d == DONE) begin
            count_d    = cnt_d;
            overflow_d = ovf_sh_d;
        end
        valid_d  = (state_d == DONE);
        osc_en_d = (state_d == SETTLE) || (state_d == MEASURE);
        busy_d   = osc_en_d;
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q     <= '0;
            tmr_q      <= '0;
            win_q      <= '0;
            cnt_q      <= '0;
            ovf_sh_q   <= 1'b0;
            osc_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            tmr_q      <= tmr_d;
            win_q      <= win_d;
            cnt_q      <= cnt_d;
            ovf_sh_q   <= ovf_sh_d;
            osc_en_q   <= osc_en_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign osc_en   = osc_en_q;
    assign busy     = busy_q;
    assign valid    = valid_q;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_ring_osc_counter.sv
// Directed bench for ring_osc_counter: a 16-bit and a 4-bit counter instance share
// the clock and a free-running oscillator model gated by each instance's osc_en.
module tb_ring_osc_counter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        sel = 1'b0;
    logic [15:0] window = '0;
    logic        osc_run;

    logic        start_a, start_b, osc_a, osc_b;
    logic        osc_en_a, busy_a, valid_a, ovf_a;
    logic        osc_en_b, busy_b, valid_b, ovf_b;
    logic [15:0] count_a;
    logic [3:0]  count_b;

    logic        valid_m, busy_m, osc_en_m, ovf_m;
    logic [15:0] count_m;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Oscillator period 40 ns = 4 clk; with DIV_LOG2=1 the tap changes every 4 clk
    initial begin
        osc_run = 1'b0;
        #3;
        forever #20 osc_run = ~osc_run;
    end

    assign osc_a   = osc_run & osc_en_a;
    assign osc_b   = osc_run & osc_en_b;
    assign start_a = start & ~sel;
    assign start_b = start & sel;

    assign valid_m  = sel ? valid_b  : valid_a;
    assign busy_m   = sel ? busy_b   : busy_a;
    assign osc_en_m = sel ? osc_en_b : osc_en_a;
    assign ovf_m    = sel ? ovf_b    : ovf_a;
    assign count_m  = sel ? 16'(count_b) : count_a;

    ring_osc_counter #(.DIV_LOG2(1), .WIN_W(16), .CNT_W(16), .SETTLE_CYCLES(16)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .window(window), .osc_en(osc_en_a),
        .osc_in(osc_a), .busy(busy_a), .valid(valid_a), .count(count_a), .overflow(ovf_a)
    );

    ring_osc_counter #(.DIV_LOG2(1), .WIN_W(16), .CNT_W(4), .SETTLE_CYCLES(16)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .window(window), .osc_en(osc_en_b),
        .osc_in(osc_b), .busy(busy_b), .valid(valid_b), .count(count_b), .overflow(ovf_b)
    );

    // Start pulse in cycle 0; returns sampled in cycle 1
    task automatic launch(input logic [15:0] w);
        @(negedge clk);
        start  = 1'b1;
        window = w;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Advance until valid is seen or the budget runs out; cyc is the current cycle index
    task automatic run_to_valid(input int cyc_in, output int cyc);
        cyc = cyc_in;
        while (valid_m !== 1'b1 && cyc < 600) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if ({osc_en_a, busy_a, valid_a, ovf_a, count_a} !== 20'd0) begin
            errors++;
            $display("FAIL reset_a: got osc_en=%b busy=%b valid=%b ovf=%b count=%0d expected all 0",
                     osc_en_a, busy_a, valid_a, ovf_a, count_a);
        end
        checks++;
        if ({osc_en_b, busy_b, valid_b, ovf_b, count_b} !== 8'd0) begin
            errors++;
            $display("FAIL reset_b: got osc_en=%b busy=%b valid=%b ovf=%b count=%0d expected all 0",
                     osc_en_b, busy_b, valid_b, ovf_b, count_b);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if ({osc_en_a, busy_a, valid_a, osc_en_b, busy_b, valid_b} !== 6'd0) begin
            errors++;
            $display("FAIL reset_idle: got osc_en/busy/valid a=%b%b%b b=%b%b%b expected 000 000",
                     osc_en_a, busy_a, valid_a, osc_en_b, busy_b, valid_b);
        end
    endtask

    task automatic test_basic(input string tag);
        int cyc;
        launch(16'd80);
        checks++;
        if (osc_en_m !== 1'b1 || busy_m !== 1'b1) begin
            errors++;
            $display("FAIL %s_cycle1: got osc_en=%b busy=%b expected 1 1", tag, osc_en_m, busy_m);
        end
        run_to_valid(1, cyc);
        checks++;
        if (cyc != 97) begin
            errors++;
            $display("FAIL %s_valid_cycle: got %0d expected 97", tag, cyc);
        end
        checks++;
        if (count_m < 16'd19 || count_m > 16'd21 || ovf_m !== 1'b0) begin
            errors++;
            $display("FAIL %s_count: got count=%0d ovf=%b expected 19..21 ovf=0", tag, count_m, ovf_m);
        end
        checks++;
        if (osc_en_m !== 1'b0 || busy_m !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_flags: got osc_en=%b busy=%b expected 0 0", tag, osc_en_m, busy_m);
        end
        @(posedge clk);
        #1;
        checks++;
        if (valid_m !== 1'b0 || count_m < 16'd19 || count_m > 16'd21) begin
            errors++;
            $display("FAIL %s_hold: got valid=%b count=%0d expected valid=0 count 19..21",
                     tag, valid_m, count_m);
        end
    endtask

    task automatic test_zero_window();
        int cyc;
        launch(16'd0);
        run_to_valid(1, cyc);
        checks++;
        if (cyc != 17) begin
            errors++;
            $display("FAIL zero_valid_cycle: got %0d expected 17", cyc);
        end
        checks++;
        if (count_m !== 16'd0 || ovf_m !== 1'b0 || osc_en_m !== 1'b0) begin
            errors++;
            $display("FAIL zero_result: got count=%0d ovf=%b osc_en=%b expected 0 0 0",
                     count_m, ovf_m, osc_en_m);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_saturation();
        int cyc;
        sel = 1'b1;
        launch(16'd200);
        run_to_valid(1, cyc);
        checks++;
        if (cyc != 217) begin
            errors++;
            $display("FAIL sat_valid_cycle: got %0d expected 217", cyc);
        end
        checks++;
        if (count_m !== 16'd15 || ovf_m !== 1'b1) begin
            errors++;
            $display("FAIL sat_result: got count=%0d ovf=%b expected 15 1", count_m, ovf_m);
        end
        @(posedge clk);
        #1;
        launch(16'd8);
        run_to_valid(1, cyc);
        checks++;
        if (cyc != 25 || count_m > 16'd2 || ovf_m !== 1'b0) begin
            errors++;
            $display("FAIL sat_short: got cyc=%0d count=%0d ovf=%b expected 25 <=2 0", cyc, count_m, ovf_m);
        end
        @(posedge clk);
        #1;
        sel = 1'b0;
    endtask

    task automatic test_busy_rules();
        int cyc;
        launch(16'd40);
        repeat (29) @(posedge clk);
        #1;
        // Retrigger with a different window in the middle of MEASURE
        @(negedge clk);
        start  = 1'b1;
        window = 16'd200;
        @(posedge clk);
        #1;
        start = 1'b0;
        run_to_valid(31, cyc);
        checks++;
        if (cyc != 57) begin
            errors++;
            $display("FAIL busy_valid_cycle: got %0d expected 57", cyc);
        end
        checks++;
        if (count_m < 16'd9 || count_m > 16'd11) begin
            errors++;
            $display("FAIL busy_count: got %0d expected 9..11", count_m);
        end
        // Start coincident with valid is dropped
        @(negedge clk);
        start  = 1'b1;
        window = 16'd16;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (busy_m !== 1'b0 || valid_m !== 1'b0) begin
            errors++;
            $display("FAIL busy_done_start: got busy=%b valid=%b expected 0 0", busy_m, valid_m);
        end
        launch(16'd16);
        checks++;
        if (busy_m !== 1'b1) begin
            errors++;
            $display("FAIL busy_next_start: got busy=%b expected 1", busy_m);
        end
        run_to_valid(1, cyc);
        checks++;
        if (cyc != 33 || count_m < 16'd3 || count_m > 16'd5) begin
            errors++;
            $display("FAIL busy_second: got cyc=%0d count=%0d expected 33 3..5", cyc, count_m);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_measure();
        int seen;
        launch(16'd80);
        repeat (39) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (osc_en_m !== 1'b0 || busy_m !== 1'b0 || valid_m !== 1'b0 || count_m !== 16'd0) begin
            errors++;
            $display("FAIL midrst_flags: got osc_en=%b busy=%b valid=%b count=%0d expected 0 0 0 0",
                     osc_en_m, busy_m, valid_m, count_m);
        end
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (120) begin
            @(posedge clk);
            #1;
            if (valid_m === 1'b1) seen++;
        end
        checks++;
        if (seen != 0 || count_m !== 16'd0) begin
            errors++;
            $display("FAIL midrst_no_valid: got valid pulses=%0d count=%0d expected 0 0", seen, count_m);
        end
        test_basic("rerun");
    endtask

    initial begin
        test_reset();
        test_basic("basic");
        test_zero_window();
        test_saturation();
        test_busy_rules();
        test_reset_mid_measure();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
